sma_stim_gen: RTL and testbench
===============================

// Module: sma_stim_gen
// PURPOSE
//  Upstream stimulus stage for the sma sequence detector: serialises a
//  parallel word onto the single-bit line x, one bit per bit-period.
//  Loaded by a controller or bench with a load/busy/done handshake.
//  Counts completed frames so a downstream checker can align to y/z activity.
// PARAMETERS
//  WIDTH     8  bits per frame (>=2)
//  PRESCALE  1  clock cycles each bit is held on x (>=1)
//  FCNT_W    8  width of completed-frame counter
// PORTS
//  clk        in   1         rising-edge clock
//  reset      in   1         synchronous, active-high reset
//  load       in   1         request to start a frame; sampled when rdy=1
//  din        in   WIDTH     frame data, captured on accepted load
//  msb_first  in   1         bit order, captured on accepted load (1=MSB first)
//  x          out  1         serial output, registered; feeds sma x
//  busy       out  1         1 while a frame is being shifted
//  rdy        out  1         combinational: state==IDLE or state==FIN
//  done       out  1         1-cycle pulse in the cycle after the last bit-period
//  frames     out  FCNT_W    completed-frame count, wraps modulo 2^FCNT_W
// BEHAVIOUR
//  Reset (sync, clk edge with reset=1): state=IDLE, x=0, busy=0, done=0,
//   frames=0, shift reg=0, bit idx=0, prescale cnt=0. Overrides all inputs.
//  States: IDLE, SEND, FIN.
//  IDLE: x=0, busy=0. load=1 -> capture din and msb_first, state=SEND,
//   idx=0, pcnt=0; first data bit is on x in the cycle after the load edge.
//  SEND: busy=1. x = current bit (din[0] first if msb_first=0, else
//   din[WIDTH-1]). pcnt increments each cycle; at pcnt==PRESCALE-1 pcnt
//   clears and the next bit is presented. After bit WIDTH-1 has been held
//   for PRESCALE cycles -> FIN. Frame occupies exactly WIDTH*PRESCALE cycles.
//  load asserted in SEND is ignored (no capture, no error); din/msb_first
//   changes in SEND do not affect the frame in flight.
//  FIN: one cycle; done=1, busy=0, x=0, frames increments by 1 (wraps
//   2^FCNT_W-1 -> 0). load=1 in FIN -> back-to-back frame: capture and
//   go to SEND (same first-bit latency as from IDLE); else -> IDLE.
//  done is high only in FIN; never two consecutive cycles.
//  Mid-frame reset aborts the frame: no done pulse, frames unchanged
//   except cleared to 0 by reset itself.
//  Unused state encoding -> IDLE on next edge.
//  x, busy, done are registered (no combinational path from load/din);
//   rdy is the only combinational output.
// TESTING
//  1 Reset: hold reset 2 cycles with load=1 -> x=0, busy=0, done=0, frames=0.
//  2 PRESCALE=1, din=8'b0000_1101, msb_first=0, one-cycle load -> x =
//    1,0,1,1,0,0,0,0 on the 8 following cycles; done=1 on cycle 9; frames=1.
//  3 Same din, msb_first=1, PRESCALE=3 -> each bit of 0,0,0,0,1,1,0,1 held
//    3 cycles; busy high 24 cycles; done on cycle 25.
//  4 load pulsed at cycle 3 of a frame with din=8'hFF -> ignored, x keeps
//    original frame, frames increments by exactly 1.
//  5 load held high continuously, din=8'hA5 -> frames back-to-back with one
//    FIN cycle (x=0, done=1) between them; FCNT_W=2 -> frames 1,2,3,0.
//  6 reset at cycle 4 of a frame -> next cycle IDLE, x=0, no done pulse;
//    feeding x into sma shows sma returns to S0 behaviour with x=0.

Source files
------------

// File: rtl/sma_stim_gen.sv
`default_nettype none
// ============================================================================
//  Module      : sma_stim_gen
//  Description : Parallel-to-serial stimulus generator for the sma sequence
//                detector. A word accepted on load is shifted onto x one bit
//                per bit-period (PRESCALE clocks). A one-cycle FIN state
//                pulses done and bumps the completed-frame counter.
//  Revision    : 1.0  initial release
// ============================================================================
module sma_stim_gen #(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 1,
    parameter int FCNT_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [WIDTH-1:0]  din,
    input  logic              msb_first,
    output logic              x,
    output logic              busy,
    output logic              rdy,
    output logic              done,
    output logic [FCNT_W-1:0] frames
);

    // Counter widths; a PRESCALE of 1 still gets a 1-bit counter that stays 0.
    localparam int IDX_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int PCNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(WIDTH - 1);
    localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PRESCALE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   shreg;      // remaining bits; next bit sits at the active end
    logic               order_msb;  // bit order latched for the frame in flight
    logic [IDX_W-1:0]   idx;        // index of the bit currently on x
    logic [PCNT_W-1:0]  pcnt;       // cycles the current bit has been held

    // Ready to accept a new frame whenever no frame is being shifted.
    assign rdy = (state == IDLE) || (state == FIN);

    // Frame sequencer: all outputs are registered from the next-state decision
    // so x/busy/done never see a combinational path from load or din.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            x         <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            frames    <= '0;
            shreg     <= '0;
            order_msb <= 1'b0;
            idx       <= '0;
            pcnt      <= '0;
        end else begin
            // done is only ever raised on the SEND->FIN edge, so it lasts one cycle.
            done <= 1'b0;

            case (state)
                IDLE, FIN: begin
                    if (load) begin
                        // Capture the frame; the first bit appears on x right away.
                        shreg     <= din;
                        order_msb <= msb_first;
                        idx       <= '0;
                        pcnt      <= '0;
                        state     <= SEND;
                        busy      <= 1'b1;
                        x         <= msb_first ? din[WIDTH-1] : din[0];
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        x     <= 1'b0;
                    end
                end

                SEND: begin
                    // load, din and msb_first are deliberately ignored here.
                    if (pcnt == PCNT_LAST) begin
                        pcnt <= '0;
                        if (idx == IDX_LAST) begin
                            state  <= FIN;
                            busy   <= 1'b0;
                            x      <= 1'b0;
                            done   <= 1'b1;
                            frames <= frames + 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                            if (order_msb) begin
                                shreg <= {shreg[WIDTH-2:0], 1'b0};
                                x     <= shreg[WIDTH-2];
                            end else begin
                                shreg <= {1'b0, shreg[WIDTH-1:1]};
                                x     <= shreg[1];
                            end
                        end
                    end else begin
                        pcnt <= pcnt + 1'b1;
                    end
                end

                default: begin
                    // Unreachable encoding: fall back to a quiet IDLE.
                    state <= IDLE;
                    busy  <= 1'b0;
                    x     <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sma_stim_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sma_stim_gen
//  Description : Self-checking bench for sma_stim_gen. Two instances share
//                the stimulus: A (PRESCALE=1, FCNT_W=2) and B (PRESCALE=3,
//                FCNT_W=8). Each is compared every cycle against a model that
//                holds the expected future of x as a list of bit-periods.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sma_stim_gen;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         load;
    logic [W-1:0] din;
    logic         msb_first;

    logic         x_a, busy_a, rdy_a, done_a;
    logic [1:0]   frames_a;
    logic         x_b, busy_b, rdy_b, done_b;
    logic [7:0]   frames_b;

    sma_stim_gen #(.WIDTH(W), .PRESCALE(1), .FCNT_W(2)) dut_a (
        .clk(clk), .reset(reset), .load(load), .din(din), .msb_first(msb_first),
        .x(x_a), .busy(busy_a), .rdy(rdy_a), .done(done_a), .frames(frames_a)
    );

    sma_stim_gen #(.WIDTH(W), .PRESCALE(3), .FCNT_W(8)) dut_b (
        .clk(clk), .reset(reset), .load(load), .din(din), .msb_first(msb_first),
        .x(x_b), .busy(busy_b), .rdy(rdy_b), .done(done_b), .frames(frames_b)
    );

    always #5 clk = ~clk;

    int tests  = 0;
    int failed = 0;

    // Model: per instance, the cycles still to come. Entries 0/1 are data
    // bit-periods, 2 is the FIN cycle; an exhausted list means idle (code 3).
    int seq [2][32];
    int rd  [2];
    int len [2];
    int frm [2];
    int prs [2]  = '{1, 3};
    int fmod [2] = '{4, 256};
    bit mvalid   = 1'b0;

    function automatic int front(input int i);
        return (rd[i] < len[i]) ? seq[i][rd[i]] : 3;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance the model across one clock edge using the inputs now applied.
    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                rd[i]  = 0;
                len[i] = 0;
                frm[i] = 0;
            end else begin
                int  f;
                bit  acc;
                f   = front(i);
                acc = ((f == 2) || (f == 3)) && load;
                if (rd[i] < len[i]) rd[i]++;
                if (acc) begin
                    rd[i]  = 0;
                    len[i] = W * prs[i] + 1;
                    for (int b = 0; b < W; b++)
                        for (int p = 0; p < prs[i]; p++)
                            seq[i][b * prs[i] + p] = msb_first ? int'(din[W-1-b]) : int'(din[b]);
                    seq[i][W * prs[i]] = 2;
                end
                if (front(i) == 2) frm[i] = (frm[i] + 1) % fmod[i];
            end
        end
        if (reset) mvalid = 1'b1;
    endtask

    // One clock: apply inputs, check rdy, take the edge, check registered outputs.
    task automatic cyc(input logic l, input logic [W-1:0] d, input logic m, input logic r);
        int fa, fb;
        load = l; din = d; msb_first = m; reset = r;
        if (mvalid) begin
            check("rdy_a", rdy_a, (front(0) >= 2) ? 1 : 0);
            check("rdy_b", rdy_b, (front(1) >= 2) ? 1 : 0);
        end
        @(posedge clk);
        model_edge();
        #1;
        fa = front(0);
        fb = front(1);
        check("x_a",      x_a,      (fa <= 1) ? fa : 0);
        check("busy_a",   busy_a,   (fa <= 1) ? 1 : 0);
        check("done_a",   done_a,   (fa == 2) ? 1 : 0);
        check("frames_a", frames_a, frm[0]);
        check("x_b",      x_b,      (fb <= 1) ? fb : 0);
        check("busy_b",   busy_b,   (fb <= 1) ? 1 : 0);
        check("done_b",   done_b,   (fb == 2) ? 1 : 0);
        check("frames_b", frames_b, frm[1]);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, W'($urandom), 1'($urandom), 1'b0);
    endtask

    initial begin
        logic [W-1:0] pat;
        logic [W-1:0] rnd;

        // Reset held two cycles with load asserted.
        cyc(1'b1, 8'hC3, 1'b0, 1'b1);
        cyc(1'b1, 8'hC3, 1'b0, 1'b1);
        check("rst_x",      x_a,      0);
        check("rst_busy",   busy_b,   0);
        check("rst_done",   done_a,   0);
        check("rst_frames", frames_b, 0);

        // LSB-first frame, PRESCALE=1 on A: x = 1,0,1,1,0,0,0,0 then done.
        pat = 8'b0000_1101;
        cyc(1'b1, pat, 1'b0, 1'b0);
        check("t2_x0", x_a, 1);
        for (int k = 1; k < W; k++) begin
            cyc(1'b0, 8'h00, 1'b0, 1'b0);
            check("t2_x", x_a, pat[k]);
        end
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        check("t2_done",   done_a,   1);
        check("t2_frames", frames_a, 1);
        idle(20);

        // MSB-first frame on B, each bit held 3 cycles for 24 busy cycles.
        cyc(1'b1, pat, 1'b1, 1'b0);
        for (int c = 0; c < 24; c++) begin
            if (c > 0) cyc(1'b0, 8'h00, 1'b0, 1'b0);
            check("t3_x",    x_b,    pat[W-1 - c/3]);
            check("t3_busy", busy_b, 1);
        end
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        check("t3_done",   done_b,   1);
        check("t3_frames", frames_b, 2);
        idle(4);

        // load pulsed mid-frame with 0xFF must be ignored.
        rnd = W'($urandom);
        cyc(1'b1, rnd, 1'b0, 1'b0);
        idle(2);
        cyc(1'b1, 8'hFF, 1'b1, 1'b0);
        idle(30);
        check("t4_frames_b", frames_b, 3);

        // load held high: back-to-back frames, A's 2-bit counter wraps.
        repeat (60) cyc(1'b1, 8'hA5, 1'b0, 1'b0);
        idle(30);

        // Reset at cycle 4 of a frame aborts it without a done pulse.
        cyc(1'b1, 8'h5A, 1'b1, 1'b0);
        idle(3);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        check("t6_x",    x_b,    0);
        check("t6_busy", busy_a, 0);
        idle(10);
        check("t6_frames", frames_b, 0);

        // Randomised traffic with occasional resets.
        for (int n = 0; n < 400; n++) begin
            cyc(($urandom_range(0, 3) == 0), W'($urandom), 1'($urandom),
                ($urandom_range(0, 59) == 0));
        end
        idle(30);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire
